rng_arbiter: RTL and testbench

Arbiter and sequencer for the verify platform's 128-bit LFSR random source. It shares the single generator between up to NUM_REQ data-generator clients, such as key and plaintext generators, using round-robin arbitration. For each grant it steps the LFSR a programmable number of times, so consecutive draws are decorrelated. It then delivers one captured 128-bit word to the winning client with a one-cycle grant/valid pulse.

---
 rtl/rng_arb_pkg.sv | 14 +
 rtl/rng_arbiter_rr_picker.sv | 30 +++
 rtl/rng_arbiter.sv | 123 ++++++++++++
 tb/tb_rng_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_arb_pkg.sv
// Shared types and constants for the LFSR draw arbiter.
package rng_arb_pkg;

  localparam int STEP_CNT_W = 8;
  localparam int RNG_WIDTH  = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STEP    = 2'd1,
    CAPTURE = 2'd2,
    DELIVER = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rng_arbiter_rr_picker.sv
// Combinational round-robin search: first set req bit at or above ptr_i,
// wrapping past NUM_REQ-1 back to 0.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  int j;

  // Walk offsets from farthest to nearest so the nearest hit wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req_i[j]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/rng_arbiter.sv
// Round-robin arbiter/sequencer sharing one 128-bit LFSR between NUM_REQ
// clients. Each draw steps the LFSR STRIDE times, captures the word and
// pulses gnt/rand_valid for one cycle.
// Optional: define RNG_ARB_DRAW_CNT_EN to add a 32-bit draw_cnt_o output
// counting delivered draws.
module rng_arbiter
  import rng_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int STRIDE  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef RNG_ARB_DRAW_CNT_EN
  output logic [31:0]          draw_cnt_o,
`endif
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [RNG_WIDTH-1:0] rand_data_o,
  output logic                 rand_valid_o,
  output logic                 busy_o,
  output logic                 lfsr_require_o,
  input  logic [RNG_WIDTH-1:0] lfsr_data_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Bad parameters are flagged at elaboration.
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("rng_arbiter: NUM_REQ=%0d outside 2..8", NUM_REQ);
  end
  if (STRIDE < 1 || STRIDE > 255) begin : g_bad_stride
    $error("rng_arbiter: STRIDE=%0d outside 1..255", STRIDE);
  end

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          win_idx_q, win_idx_d;
  logic [STEP_CNT_W-1:0]     step_cnt_q, step_cnt_d;
  logic [RNG_WIDTH-1:0]      rand_data_q, rand_data_d;

  logic                      pick_found;
  logic [IDX_W-1:0]          pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // State and datapath registers; reset aborts any draw in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      win_idx_q   <= '0;
      step_cnt_q  <= '0;
      rand_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_idx_q   <= win_idx_d;
      step_cnt_q  <= step_cnt_d;
      rand_data_q <= rand_data_d;
    end
  end

  // Next-state: requests are only looked at in IDLE, so a dropped req
  // mid-draw still gets its word.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_idx_d   = win_idx_q;
    step_cnt_d  = step_cnt_q;
    rand_data_d = rand_data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          win_idx_d  = pick_idx;
          step_cnt_d = STEP_CNT_W'(STRIDE - 1);
          state_d    = STEP;
        end
      end
      STEP: begin
        if (step_cnt_q == '0) state_d = CAPTURE;
        else                  step_cnt_d = step_cnt_q - STEP_CNT_W'(1);
      end
      CAPTURE: begin
        rand_data_d = lfsr_data_i;
        state_d     = DELIVER;
      end
      DELIVER: begin
        rr_ptr_d = (win_idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state only; no path from req_i.
  assign rand_valid_o   = (state_q == DELIVER);
  assign gnt_o          = rand_valid_o ? (NUM_REQ'(1) << win_idx_q) : '0;
  assign busy_o         = (state_q != IDLE);
  assign lfsr_require_o = (state_q == STEP);
  assign rand_data_o    = rand_data_q;

`ifdef RNG_ARB_DRAW_CNT_EN
  logic [31:0] draw_cnt_q;

  // Delivered-draw counter, free-running wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 draw_cnt_q <= '0;
    else if (state_q == DELIVER) draw_cnt_q <= draw_cnt_q + 32'd1;
  end

  assign draw_cnt_o = draw_cnt_q;
`endif

endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter: one instance at STRIDE=1, one at STRIDE=8,
// each driving a small left-shift LFSR model seeded with 128'h53504402.
module tb_rng_arbiter;

  localparam logic [127:0] SEED = 128'h53504402;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req1 = '0, req8 = '0;
  logic [3:0]   gnt1, gnt8;
  logic [127:0] data1, data8;
  logic         vld1, vld8, busy1, busy8, rq1, rq8;
  logic [127:0] lf1, lf8;
`ifdef RNG_ARB_DRAW_CNT_EN
  logic [31:0]  cnt1, cnt8;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  rng_arbiter #(.NUM_REQ(4), .STRIDE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n),
`ifdef RNG_ARB_DRAW_CNT_EN
    .draw_cnt_o(cnt1),
`endif
    .req_i(req1), .gnt_o(gnt1), .rand_data_o(data1), .rand_valid_o(vld1),
    .busy_o(busy1), .lfsr_require_o(rq1), .lfsr_data_i(lf1)
  );

  rng_arbiter #(.NUM_REQ(4), .STRIDE(8)) u_s8 (
    .clk(clk), .rst_n(rst_n),
`ifdef RNG_ARB_DRAW_CNT_EN
    .draw_cnt_o(cnt8),
`endif
    .req_i(req8), .gnt_o(gnt8), .rand_data_o(data8), .rand_valid_o(vld8),
    .busy_o(busy8), .lfsr_require_o(rq8), .lfsr_data_i(lf8)
  );

  // LFSR stand-ins: shift left with feedback from high taps.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf1 <= SEED;
      lf8 <= SEED;
    end else begin
      if (rq1) lf1 <= {lf1[126:0], lf1[127] ^ lf1[125] ^ lf1[100] ^ lf1[98]};
      if (rq8) lf8 <= {lf8[126:0], lf8[127] ^ lf8[125] ^ lf8[100] ^ lf8[98]};
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req1  = '0;
    req8  = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drive req and tick until the selected instance pulses valid.
  task automatic run_draw(input bit big, input logic [3:0] r,
                          output int lat, output int nreq,
                          output logic [3:0] g, output logic [127:0] d);
    lat = 0; nreq = 0; g = '0; d = '0;
    if (big) req8 = r; else req1 = r;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (big ? rq8 : rq1) nreq++;
      if (big ? vld8 : vld1) begin
        lat = n;
        g   = big ? gnt8 : gnt1;
        d   = big ? data8 : data1;
        break;
      end
    end
    if (lat == 0) begin
      checks++; fails++;
      $display("FAIL draw_timeout big=%0d req=%b: no rand_valid within 40 cycles", big, r);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks += 10;
    if (gnt8  !== 4'b0) begin fails++; $display("FAIL rst_gnt8 got %b want 0000", gnt8); end
    if (vld8  !== 1'b0) begin fails++; $display("FAIL rst_vld8 got %b want 0", vld8); end
    if (busy8 !== 1'b0) begin fails++; $display("FAIL rst_busy8 got %b want 0", busy8); end
    if (rq8   !== 1'b0) begin fails++; $display("FAIL rst_req8 got %b want 0", rq8); end
    if (data8 !== 128'h0) begin fails++; $display("FAIL rst_data8 got %h want 0", data8); end
    if (gnt1  !== 4'b0) begin fails++; $display("FAIL rst_gnt1 got %b want 0000", gnt1); end
    if (vld1  !== 1'b0) begin fails++; $display("FAIL rst_vld1 got %b want 0", vld1); end
    if (busy1 !== 1'b0) begin fails++; $display("FAIL rst_busy1 got %b want 0", busy1); end
    if (rq1   !== 1'b0) begin fails++; $display("FAIL rst_req1 got %b want 0", rq1); end
    if (data1 !== 128'h0) begin fails++; $display("FAIL rst_data1 got %h want 0", data1); end
    do_reset();
  endtask

  task automatic test_stride1;
    int lat, nreq; logic [3:0] g; logic [127:0] d;
    do_reset();
    run_draw(1'b0, 4'b0001, lat, nreq, g, d);
    req1 = '0;
    checks += 4;
    if (lat  !== 3) begin fails++; $display("FAIL s1_latency got %0d want 3", lat); end
    if (nreq !== 1) begin fails++; $display("FAIL s1_require_cycles got %0d want 1", nreq); end
    if (g !== 4'b0001) begin fails++; $display("FAIL s1_gnt got %b want 0001", g); end
    if (d !== 128'hA6A08804) begin fails++; $display("FAIL s1_data got %h want a6a08804", d); end
    repeat (3) tick();
    checks += 2;
    if (data1 !== 128'hA6A08804) begin fails++; $display("FAIL s1_data_hold got %h want a6a08804", data1); end
    if (busy1 !== 1'b0) begin fails++; $display("FAIL s1_idle_busy got %b want 0", busy1); end
  endtask

  task automatic test_stride8;
    int lat, nreq; logic [3:0] g; logic [127:0] d;
    do_reset();
    run_draw(1'b1, 4'b0100, lat, nreq, g, d);
    req8 = '0;
    checks += 4;
    if (lat  !== 10) begin fails++; $display("FAIL s8_latency got %0d want 10", lat); end
    if (nreq !== 8) begin fails++; $display("FAIL s8_require_cycles got %0d want 8", nreq); end
    if (g !== 4'b0100) begin fails++; $display("FAIL s8_gnt got %b want 0100", g); end
    if (d !== 128'h5350440200) begin fails++; $display("FAIL s8_data got %h want 5350440200", d); end
    repeat (2) tick();
  endtask

  task automatic test_round_robin;
    int lat, nreq, last; logic [3:0] g; logic [127:0] d;
    logic [3:0] exp_g;
    do_reset();
    last = 0;
    for (int k = 0; k < 8; k++) begin
      run_draw(1'b1, 4'b1111, lat, nreq, g, d);
      exp_g = 4'b0001 << (k % 4);
      checks++;
      if (g !== exp_g) begin fails++; $display("FAIL rr_gnt draw %0d got %b want %b", k, g, exp_g); end
      if (k > 0) begin
        checks++;
        if (cyc - last !== 11) begin fails++; $display("FAIL rr_period draw %0d got %0d want 11", k, cyc - last); end
      end
      last = cyc;
    end
    req8 = '0;
    repeat (2) tick();
  endtask

  task automatic test_withdraw;
    int lat, nreq; logic [3:0] g; logic [127:0] d;
    req8 = 4'b0010;
    tick();
    req8 = 4'b0000;
    checks++;
    if (busy8 !== 1'b1) begin fails++; $display("FAIL wd_busy_step got %b want 1", busy8); end
    run_draw(1'b1, 4'b0000, lat, nreq, g, d);
    checks++;
    if (g !== 4'b0010) begin fails++; $display("FAIL wd_gnt got %b want 0010", g); end
    tick();
    checks += 2;
    if (busy8 !== 1'b0) begin fails++; $display("FAIL wd_busy_idle got %b want 0", busy8); end
    if (vld8 !== 1'b0) begin fails++; $display("FAIL wd_vld_idle got %b want 0", vld8); end
    repeat (3) tick();
    checks++;
    if (busy8 !== 1'b0) begin fails++; $display("FAIL wd_stays_idle got %b want 0", busy8); end
  endtask

  task automatic test_reset_mid;
    int lat, nreq; logic [3:0] g; logic [127:0] d;
    do_reset();
    // Leave rr_ptr at 2 so a non-reset pointer would pick client 2 next.
    run_draw(1'b1, 4'b0010, lat, nreq, g, d);
    req8 = '0;
    tick();
    req8 = 4'b0110;
    repeat (3) tick();
    checks++;
    if (rq8 !== 1'b1) begin fails++; $display("FAIL mid_in_step got %b want 1", rq8); end
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (rq8 !== 1'b0) begin fails++; $display("FAIL mid_require_async got %b want 0", rq8); end
    if (vld8 !== 1'b0) begin fails++; $display("FAIL mid_vld got %b want 0", vld8); end
    if (gnt8 !== 4'b0) begin fails++; $display("FAIL mid_gnt got %b want 0000", gnt8); end
    if (busy8 !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy8); end
    if (data8 !== 128'h0) begin fails++; $display("FAIL mid_data got %h want 0", data8); end
    if (u_s8.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL mid_rr_ptr got %0d want 0", u_s8.rr_ptr_q); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (vld8 !== 1'b0 || gnt8 !== 4'b0) begin
        fails++; $display("FAIL mid_no_pulse got vld=%b gnt=%b want 0/0000", vld8, gnt8);
      end
    end
    rst_n = 1'b1;
    run_draw(1'b1, 4'b0110, lat, nreq, g, d);
    req8 = '0;
    checks += 2;
    if (g !== 4'b0010) begin fails++; $display("FAIL mid_next_gnt got %b want 0010", g); end
    if (d !== 128'h5350440200) begin fails++; $display("FAIL mid_next_data got %h want 5350440200", d); end
    repeat (2) tick();
  endtask

`ifdef RNG_ARB_DRAW_CNT_EN
  task automatic test_draw_cnt;
    int lat, nreq; logic [3:0] g; logic [127:0] d;
    do_reset();
    for (int k = 0; k < 5; k++) run_draw(1'b0, 4'b0001, lat, nreq, g, d);
    req1 = '0;
    tick();
    checks++;
    if (cnt1 !== 32'd5) begin fails++; $display("FAIL cnt_five got %0d want 5", cnt1); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (cnt1 !== 32'd0) begin fails++; $display("FAIL cnt_reset got %0d want 0", cnt1); end
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_stride1();
    test_stride8();
    test_round_robin();
    test_withdraw();
    test_reset_mid();
`ifdef RNG_ARB_DRAW_CNT_EN
    test_draw_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
